// File: rtl/frame_load_ctrl.sv
// Frame load controller: turns a stream of config words into one column
// frame. An address word selects a column (or all columns) and a strobe
// mask. The next NumberOfRows words fill the row registers, starting at
// row 0. The controller then strobes the mask into the selected column(s)
// for exactly one cycle.
//
// Handshake: a word is transferred on every rising edge where WriteStrobe
// is 1. There is no back-pressure, so the block accepts a word on every
// cycle. Abort in the same cycle wins, and that word is dropped.
module frame_load_ctrl #(
    parameter int NumberOfRows     = 8,
    parameter int NumberOfCols     = 10,
    parameter int FrameBitsPerRow  = 32,
    parameter int MaxFramesPerCol  = 20,
    parameter int FrameSelectWidth = 5,
    parameter logic [FrameBitsPerRow-1:0] PadWord = 32'h12345678
) (
    input  logic                                        CLK,
    input  logic                                        resetn,
    input  logic [FrameBitsPerRow-1:0]                  WriteData,
    input  logic                                        WriteStrobe,
    input  logic                                        Abort,
    input  logic                                        ClearError,
    output logic [FrameBitsPerRow*(NumberOfRows+2)-1:0] FrameData,
    output logic [MaxFramesPerCol*NumberOfCols-1:0]     FrameStrobe,
    output logic                                        Busy,
    output logic                                        FrameDone,
    output logic                                        AddrError,
    output logic [1:0]                                  debug_state
);

    localparam int RowW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_STROBE = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_next;
    logic [FrameSelectWidth-1:0] addr_col;
    logic [FrameSelectWidth-1:0] col_q;
    logic [MaxFramesPerCol-1:0]  mask_q;
    logic                        bcast_q;
    logic [RowW-1:0]             row_cnt;
    logic [FrameBitsPerRow-1:0]  rows [NumberOfRows];

    logic addr_cycle;
    logic addr_bcast;
    logic addr_legal;
    logic addr_ok;
    logic addr_bad;
    logic data_write;
    logic last_row;

    // Outside DATA, every accepted word is an address word. Inside DATA it never is.
    assign addr_col   = WriteData[FrameBitsPerRow-1 -: FrameSelectWidth];
    assign addr_cycle = WriteStrobe && !Abort && (state != S_DATA);
    assign addr_bcast = &addr_col;
    assign addr_legal = int'(addr_col) < NumberOfCols;
    assign addr_ok    = addr_cycle && (addr_bcast || addr_legal);
    assign addr_bad   = addr_cycle && !addr_bcast && !addr_legal;
    assign data_write = WriteStrobe && !Abort && (state == S_DATA);
    assign last_row   = (row_cnt == RowW'(NumberOfRows - 1));

    assign debug_state = state;

    // State register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: Abort always returns to IDLE; STROBE chains into DATA with no bubble
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (addr_ok) state_next = S_DATA;
            end
            S_DATA: begin
                if (Abort)                      state_next = S_IDLE;
                else if (data_write && last_row) state_next = S_STROBE;
            end
            S_STROBE: begin
                state_next = addr_ok ? S_DATA : S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs: strobe and done exist only during the single STROBE cycle
    always_comb begin
        Busy        = (state == S_DATA) || (state == S_STROBE);
        FrameDone   = (state == S_STROBE);
        FrameStrobe = '0;
        if (state == S_STROBE) begin
            for (int c = 0; c < NumberOfCols; c++) begin
                if (bcast_q || (col_q == FrameSelectWidth'(c))) begin
                    FrameStrobe[c*MaxFramesPerCol +: MaxFramesPerCol] = mask_q;
                end
            end
        end
    end

    // Frame target, row pointer and sticky error; an illegal address latches nothing
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            row_cnt   <= '0;
            col_q     <= '0;
            mask_q    <= '0;
            bcast_q   <= 1'b0;
            AddrError <= 1'b0;
        end else begin
            if (Abort) begin
                row_cnt <= '0;
            end else if (addr_ok) begin
                row_cnt <= '0;
                col_q   <= addr_col;
                mask_q  <= WriteData[MaxFramesPerCol-1:0];
                bcast_q <= addr_bcast;
            end else if (data_write) begin
                row_cnt <= last_row ? '0 : row_cnt + RowW'(1);
            end
            if (addr_bad) begin
                AddrError <= 1'b1;
            end else if (ClearError) begin
                AddrError <= 1'b0;
            end
        end
    end

    // Row registers keep their contents until rewritten, so FrameData is stable between writes
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NumberOfRows; r++) begin
                rows[r] <= '0;
            end
        end else if (data_write) begin
            rows[row_cnt] <= WriteData;
        end
    end

    // Frame data bus: pad word, rows from highest to lowest, pad word
    assign FrameData[FrameBitsPerRow-1:0] = PadWord;
    assign FrameData[FrameBitsPerRow*(NumberOfRows+2)-1 -: FrameBitsPerRow] = PadWord;
    for (genvar r = 0; r < NumberOfRows; r++) begin : g_rows
        assign FrameData[FrameBitsPerRow*(r+1) +: FrameBitsPerRow] = rows[r];
    end

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Testbench for frame_load_ctrl at default parameters.
module tb_frame_load_ctrl;

    localparam int ROWS = 8;
    localparam int COLS = 10;
    localparam int FBR  = 32;
    localparam int MFC  = 20;
    localparam int FSW  = 5;
    localparam logic [31:0] PAD = 32'h12345678;
    localparam int FD_W = FBR * (ROWS + 2);
    localparam int FS_W = MFC * COLS;

    // ---------------- clock / reset ----------------
    logic            CLK = 1'b0;
    logic            resetn = 1'b1;
    logic [FBR-1:0]  WriteData = '0;
    logic            WriteStrobe = 1'b0;
    logic            Abort = 1'b0;
    logic            ClearError = 1'b0;
    logic [FD_W-1:0] FrameData;
    logic [FS_W-1:0] FrameStrobe;
    logic            Busy;
    logic            FrameDone;
    logic            AddrError;
    logic [1:0]      debug_state;

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    frame_load_ctrl dut (
        .CLK         (CLK),
        .resetn      (resetn),
        .WriteData   (WriteData),
        .WriteStrobe (WriteStrobe),
        .Abort       (Abort),
        .ClearError  (ClearError),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .Busy        (Busy),
        .FrameDone   (FrameDone),
        .AddrError   (AddrError),
        .debug_state (debug_state)
    );

    // ---------------- scoreboard + reference model ----------------
    int n_checks = 0;
    int n_errors = 0;
    bit mon_en = 1'b0;

    logic [FD_W-1:0] exp_q[$];
    logic [FS_W-1:0] exp_strobe_q[$];
    int              exp_cyc_q[$];

    logic [31:0] m_rows [ROWS];
    bit          m_in_data;
    int          m_cnt;
    logic [4:0]  m_col;
    logic [19:0] m_mask;
    bit          m_bcast;
    bit          m_err;

    task automatic check(input string tag, input logic [FD_W-1:0] act, input logic [FD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [FD_W-1:0] model_frame();
        logic [FD_W-1:0] f;
        f = '0;
        f[FBR-1:0] = PAD;
        f[FD_W-1 -: FBR] = PAD;
        for (int r = 0; r < ROWS; r++) f[FBR*(r+1) +: FBR] = m_rows[r];
        return f;
    endfunction

    function automatic logic [FS_W-1:0] model_strobe();
        logic [FS_W-1:0] s;
        s = '0;
        for (int c = 0; c < COLS; c++)
            if (m_bcast || (int'(m_col) == c)) s[c*MFC +: MFC] = m_mask;
        return s;
    endfunction

    // Compare committed frames when the DUT signals them; strobe must be quiet otherwise
    always @(negedge CLK) begin
        if (mon_en && resetn) begin
            if (FrameDone) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", FrameDone, 1'b0);
                end else begin
                    check("done_data", FrameData, exp_q.pop_front());
                    check("done_strobe", FrameStrobe, exp_strobe_q.pop_front());
                    check("done_cycle", cyc, exp_cyc_q.pop_front());
                end
            end else begin
                check("strobe_idle", FrameStrobe, '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All drivers start and end 1 time unit after a rising edge.
    task automatic put(input logic [31:0] w, input bit clr = 1'b0);
        bit new_err;
        logic [4:0] c;
        new_err = 1'b0;
        c = w[31:27];
        if (m_in_data) begin
            m_rows[m_cnt] = w;
            m_cnt++;
            if (m_cnt == ROWS) begin
                exp_q.push_back(model_frame());
                exp_strobe_q.push_back(model_strobe());
                exp_cyc_q.push_back(cyc + 1);
                m_in_data = 1'b0;
                m_cnt = 0;
            end
        end else if (c == 5'h1f) begin
            m_bcast = 1'b1; m_mask = w[19:0]; m_in_data = 1'b1; m_cnt = 0;
        end else if (int'(c) < COLS) begin
            m_bcast = 1'b0; m_col = c; m_mask = w[19:0]; m_in_data = 1'b1; m_cnt = 0;
        end else begin
            new_err = 1'b1;
        end
        if (new_err) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        ClearError = clr;
        WriteData = w;
        WriteStrobe = 1'b1;
        @(posedge CLK);
        #1;
        WriteStrobe = 1'b0;
        ClearError = 1'b0;
        WriteData = $urandom();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            WriteData = $urandom();
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clear_err();
        ClearError = 1'b1;
        @(posedge CLK);
        #1;
        ClearError = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic do_abort(input bit with_word);
        Abort = 1'b1;
        if (with_word) begin
            WriteStrobe = 1'b1;
            WriteData = 32'hDEADBEEF;
        end
        @(posedge CLK);
        #1;
        Abort = 1'b0;
        WriteStrobe = 1'b0;
        m_in_data = 1'b0;
        m_cnt = 0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        for (int r = 0; r < ROWS; r++) m_rows[r] = '0;
        m_in_data = 1'b0; m_cnt = 0; m_err = 1'b0;
        check("rst_strobe", FrameStrobe, '0);
        check("rst_done", FrameDone, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_err", AddrError, 1'b0);
        check("rst_state", debug_state, 2'd0);
        check("rst_data", FrameData, model_frame());
        @(negedge CLK);
        resetn = 1'b1;
        mon_en = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] addr, input bit gaps);
        put(addr);
        for (int i = 0; i < ROWS; i++) begin
            put($urandom());
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [FS_W-1:0] k;
        logic [31:0]     addr;

        #2;
        do_reset();

        // Column 3, mask 5: strobe bits 60 and 62
        put(32'h18000005);
        check("t34_busy", Busy, 1'b1);
        check("t34_state", debug_state, 2'd1);
        for (int i = 1; i <= ROWS; i++) put(32'h11111111 * i);
        k = '0; k[60] = 1'b1; k[62] = 1'b1;
        check("t34_strobe", FrameStrobe, k);
        check("t34_done", FrameDone, 1'b1);
        check("t34_row0", FrameData[63:32], 32'h11111111);
        check("t34_row7", FrameData[287:256], 32'h88888888);
        check("t34_padlo", FrameData[31:0], PAD);
        check("t34_padhi", FrameData[319:288], PAD);
        idle(2);
        check("t34_after", debug_state, 2'd0);

        // Broadcast, mask 1: bit 0 of every column
        put(32'hF8000001);
        for (int i = 0; i < ROWS; i++) put($urandom());
        k = '0;
        for (int c = 0; c < COLS; c++) k[c*MFC] = 1'b1;
        check("t35_strobe", FrameStrobe, k);
        idle(2);

        // Illegal column 12, then clear; then set and clear in the same cycle
        put(32'h60000001);
        check("t36_err", AddrError, m_err);
        check("t36_busy", Busy, 1'b0);
        idle(1);
        check("t36_sticky", AddrError, 1'b1);
        clear_err();
        check("t36_clr", AddrError, m_err);
        put(32'h58000000, 1'b1);
        check("t30_setwins", AddrError, m_err);
        clear_err();

        // Abort after 4 words; Abort beats a simultaneous WriteStrobe
        put(32'h08000003);
        for (int i = 0; i < 4; i++) put($urandom());
        do_abort(1'b1);
        check("t37_state", debug_state, 2'd0);
        check("t37_busy", Busy, 1'b0);
        check("t37_rows", FrameData, model_frame());
        idle(3);

        // Back-to-back frames: next address lands in the STROBE cycle
        put(32'h20000abc);
        for (int i = 0; i < ROWS; i++) put(i == 2 ? 32'h60000000 : $urandom());
        check("t31_noerr", AddrError, 1'b0);
        put(32'h48000fff);
        check("t38_state", debug_state, 2'd1);
        for (int i = 0; i < ROWS; i++) put($urandom());
        put(32'h68000000);
        check("t38_bad_err", AddrError, m_err);
        check("t38_bad_state", debug_state, 2'd0);
        clear_err();

        // Mask of zero still commits data and pulses FrameDone
        put(32'h10000000);
        for (int i = 0; i < ROWS; i++) put($urandom());
        check("t27_done", FrameDone, 1'b1);
        check("t27_strobe", FrameStrobe, '0);
        idle(1);

        // WriteData wiggling with WriteStrobe low changes nothing
        idle(4);
        check("t31_hold", FrameData, model_frame());

        // Reset mid-frame discards the partial frame, then a clean frame follows
        put(32'h38000010);
        for (int i = 0; i < 5; i++) put($urandom());
        do_reset();
        put(32'h40000002);
        for (int i = 0; i < ROWS; i++) put($urandom());
        idle(2);

        // Random frames with occasional gaps between data words
        for (int f = 0; f < 8; f++) begin
            addr = $urandom();
            addr[31:27] = (f % 4 == 3) ? 5'h1f : 5'($urandom_range(0, COLS - 1));
            send_frame(addr, f[0]);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end

        idle(4);
        check("pending", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_load_ctrl.md
FRAME_LOAD_CTRL -- requirements
Module: frame_load_ctrl

Interface
REQ-001 SHALL have parameter NumberOfRows, default 8, fabric rows, each with one frame data word.
REQ-002 SHALL have parameter NumberOfCols, default 10, fabric columns, each with its own frame strobe group.
REQ-003 SHALL have parameter FrameBitsPerRow, default 32, width of a config word and of a row data word.
REQ-004 SHALL have parameter MaxFramesPerCol, default 20, strobe lines per column.
REQ-005 SHALL have parameter FrameSelectWidth, default 5, width of the column field in an address word.
REQ-006 SHALL have parameter PadWord, default 32'h12345678, constant placed above and below the row data.
REQ-007 SHALL have port CLK  in  1  single clock; all state changes on the rising edge.
REQ-008 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port WriteData  in  FrameBitsPerRow  incoming config word.
REQ-010 SHALL have port WriteStrobe  in  1  one-cycle qualifier; one word per high cycle.
REQ-011 SHALL have port Abort  in  1  synchronous cancel of the frame in progress.
REQ-012 SHALL have port ClearError  in  1  synchronous clear of AddrError.
REQ-013 SHALL have port FrameData  out  FrameBitsPerRow*(NumberOfRows+2)  {PadWord, row NumberOfRows-1 .. row 0, PadWord}.
REQ-014 SHALL have port FrameStrobe  out  MaxFramesPerCol*NumberOfCols  column c occupies bits [c*MaxFramesPerCol +: MaxFramesPerCol].
REQ-015 SHALL have port Busy  out  1  high in DATA or STROBE state.
REQ-016 SHALL have port FrameDone  out  1  one-cycle pulse when a frame is committed.
REQ-017 SHALL have port AddrError  out  1  sticky illegal-column flag.

Function
REQ-018 SHALL implement FSM states IDLE, DATA, STROBE.
REQ-019 In IDLE or STROBE, a WriteStrobe word SHALL be an address word: column = bits [FrameBitsPerRow-1 -: FrameSelectWidth]; mask = bits [MaxFramesPerCol-1:0].
REQ-020 An address word with column < NumberOfCols SHALL latch column and mask, clear RowCnt to 0 and move to DATA.
REQ-021 A column of all ones SHALL be broadcast: latch mask, apply it to every column at commit, move to DATA.
REQ-022 Any other column value SHALL set AddrError, latch nothing, and enter or stay in IDLE.
REQ-023 In DATA, each WriteStrobe SHALL write WriteData into row register RowCnt and increment RowCnt; row 0 is written first.
REQ-024 The write that fills row NumberOfRows-1 SHALL move the FSM to STROBE.
REQ-025 In STROBE, for exactly one cycle, FrameStrobe SHALL carry the latched mask in the selected column (all columns if broadcast) with zeros elsewhere, and FrameDone SHALL be 1; otherwise both SHALL be 0.
REQ-026 From STROBE, the FSM SHALL go to DATA if a legal address word is accepted that cycle, else to IDLE; back-to-back frames have zero bubble.
REQ-027 A mask of 0 SHALL be legal: data is loaded, FrameStrobe stays 0, FrameDone still pulses.
REQ-028 Abort SHALL force IDLE on the next edge, clear RowCnt, and suppress the strobe; rows already written keep their values; Abort has priority over WriteStrobe.
REQ-029 Row registers SHALL hold their values until rewritten, so FrameData is stable between writes.
REQ-030 When a new error and ClearError occur in the same cycle, set SHALL win; ClearError alone SHALL clear AddrError on the next edge.
REQ-031 WriteStrobe in DATA SHALL never be treated as an address word; WriteData SHALL be ignored while WriteStrobe is 0.

Reset
REQ-032 On resetn low, asynchronously: FSM in IDLE, RowCnt 0, all row registers 0, FrameStrobe 0, FrameDone 0, Busy 0, AddrError 0.
REQ-033 After reset, FrameData SHALL read {PadWord, zeros, PadWord}; reset during DATA SHALL discard the partial frame with no strobe.

Verification (default parameters)
REQ-034 Addr 32'h18000005, then data 32'h11111111..32'h88888888 -> one cycle later FrameStrobe bits 60 and 62 high for 1 cycle, FrameDone=1; FrameData[63:32]=11111111, [287:256]=88888888, [31:0]=[319:288]=12345678.
REQ-035 Addr 32'hF8000001 plus 8 data words -> FrameStrobe bits 0,20,40,...,180 high together for one cycle.
REQ-036 Addr 32'h60000001 (column 12) -> AddrError=1, Busy=0, no strobe; then ClearError -> AddrError=0.
REQ-037 Addr 32'h08000003, 4 data words, then Abort -> IDLE, no strobe, rows 0-3 updated, rows 4-7 unchanged.
REQ-038 Address word issued in the STROBE cycle -> FSM goes directly to DATA; the second frame commits after 8 further words.
REQ-039 resetn low after 5 data words -> all outputs at reset values; the next address word starts a clean frame.
